// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC event readout path.
// Event word layout, frame header byte and reader FSM states.
package tdc_pkg;

    localparam int TDC_CHAN_W = 4;
    localparam int TDC_TOT_W  = 32;
    localparam int TDC_TS_W   = 32;

    localparam logic [7:0] TDC_FRAME_HEADER = 8'hA5;

    typedef struct packed {
        logic [TDC_CHAN_W-1:0] chan;
        logic [TDC_TOT_W-1:0]  tot;
        logic [TDC_TS_W-1:0]   ts;
    } tdc_event_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_POP,
        RD_LATCH,
        RD_SEND
    } tdc_rd_state_e;

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step: poly 0x07, MSB first, no reflection.
// Purely combinational; chain it once per payload byte.
module crc8_update (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    // Shift the byte through the CRC register one bit at a time.
    always_comb begin
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/tdc_event_reader.sv
// Drains the TDC event FIFO and frames each event as a byte stream.
// Define TDC_READER_CRC_EN to append a CRC-8 trailer over the payload.
module tdc_event_reader
    import tdc_pkg::*;
#(
    parameter int         DATA_LENGTH = 68,
    parameter int         CHAN_W      = TDC_CHAN_W,
    parameter int         TOT_W       = TDC_TOT_W,
    parameter int         TS_W        = TDC_TS_W,
    parameter logic [7:0] HEADER      = TDC_FRAME_HEADER,
    parameter int         CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_LENGTH-1:0] fifo_rdata,
    output logic                   fifo_read,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       events_sent
);

    localparam int NB   = (DATA_LENGTH + 7) / 8;
    localparam int SR_W = NB * 8;
`ifdef TDC_READER_CRC_EN
    localparam int FRAME_LEN = NB + 2;
`else
    localparam int FRAME_LEN = NB + 1;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    tdc_rd_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cur_byte;
    logic             is_payload;
    logic             is_last;

`ifdef TDC_READER_CRC_EN
    logic [7:0] crc_q, crc_d, crc_next;

    crc8_update u_crc (
        .crc_in  (crc_q),
        .byte_in (sr_q[SR_W-1 -: 8]),
        .crc_out (crc_next)
    );
`endif

    // Select the byte on the link from the frame position.
    always_comb begin
        is_last    = (idx_q == LAST_IDX);
        is_payload = (idx_q != '0);
        cur_byte   = sr_q[SR_W-1 -: 8];
        if (idx_q == '0) begin
            cur_byte = HEADER;
        end
`ifdef TDC_READER_CRC_EN
        if (is_last) begin
            is_payload = 1'b0;
            cur_byte   = crc_q;
        end
`endif
    end

    // Next-state and Moore outputs; the pop is gated by the live empty flag.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        fifo_read = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy      = (state_q != RD_IDLE);
`ifdef TDC_READER_CRC_EN
        crc_d     = crc_q;
`endif
        unique case (state_q)
            RD_IDLE: begin
                if (!fifo_empty) begin
                    state_d = RD_POP;
                end
            end
            RD_POP: begin
                if (fifo_empty) begin
                    state_d = RD_IDLE;
                end else begin
                    fifo_read = 1'b1;
                    state_d   = RD_LATCH;
                end
            end
            RD_LATCH: begin
                sr_d    = SR_W'(fifo_rdata);
                idx_d   = '0;
                state_d = RD_SEND;
`ifdef TDC_READER_CRC_EN
                crc_d   = 8'h00;
`endif
            end
            RD_SEND: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (is_payload) begin
                        sr_d = sr_q << 8;
`ifdef TDC_READER_CRC_EN
                        crc_d = crc_next;
`endif
                    end
                    if (is_last) begin
                        idx_d   = '0;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RD_IDLE;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef TDC_READER_CRC_EN
            crc_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
`ifdef TDC_READER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign events_sent = cnt_q;

endmodule
